// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
// Contents:
//   INSTR_W, PC_STEP, NOP, DEFAULT_RESET_PC   fetch-wide constants
//   fetch_entry_t                              prefetch buffer entry {pc, instr}
//   fetch_state_t                              request tracker state
//   word_align()                               clears the byte-offset bits of an address
package instr_fetch_unit_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // FS_IDLE: no request outstanding
    // FS_BUSY: request outstanding, its word will be kept
    // FS_DROP: request outstanding, but a redirect has made its word stale
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_BUSY = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~(PC_STEP - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch buffer: synchronous push/pop/flush FIFO with occupancy count
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push_i, push_data_i write an entry (ignored when full or flushing)
//   pop_i               retire the head entry (ignored when empty or flushing)
//   flush_i             empty the buffer; wins over push and pop on the same edge
//   head_data_o         oldest entry (meaningful only when !empty_o)
//   empty_o, count_o    occupancy status
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         head_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && (count_q != CNT_W'(DEPTH)) && !flush_i;
    assign do_pop  = pop_i  && (count_q != '0)            && !flush_i;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= push_data_i;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, single-outstanding imem reads, prefetch buffer, redirect
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   imem_req/imem_addr             read request, held stable until imem_ack
//   imem_ack/imem_rdata            read completion and returned word
//   redirect/redirect_pc           one-cycle restart of fetch at a new address
//   instr_valid/instr_ready        decode handshake on the buffer head
//   instr/instr_pc/instr_pc_plus4  head word, its address, address + 4
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic                 imem_ack,
    input  logic [INSTR_W-1:0]   imem_rdata,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [INSTR_W-1:0]   instr,
    output logic [31:0]          instr_pc,
    output logic [31:0]          instr_pc_plus4
);

    localparam int               CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    fetch_state_t state_q, state_d;
    logic [31:0]  fpc_q, fpc_d;      // address of the next word to be buffered
    logic [31:0]  addr_q, addr_d;    // address presented on imem_addr

    logic             accept;
    logic [31:0]      target;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_after_push;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

    assign accept = (state_q != FS_IDLE) && imem_ack;
    assign target = word_align(redirect_pc);

    // Occupancy once this edge's push and pop have both landed; a new request
    // is only launched back-to-back if its word is guaranteed a slot.
    assign count_after_push = fifo_count + CNT_W'(1) - CNT_W'(fifo_pop);

    assign push_entry = '{pc: fpc_q, instr: imem_rdata};

    always_comb begin
        state_d   = state_q;
        fpc_d     = fpc_q;
        addr_d    = addr_q;
        fifo_push = 1'b0;
        unique case (state_q)
            FS_IDLE: begin
                if (redirect) begin
                    fpc_d   = target;
                    addr_d  = target;
                    state_d = FS_BUSY;
                end else if (fifo_count < DEPTH_CNT) begin
                    addr_d  = fpc_q;
                    state_d = FS_BUSY;
                end
            end
            FS_BUSY: begin
                if (redirect) begin
                    fpc_d = target;
                    if (accept) begin
                        // Returning word belongs to the old path; fetch the target now.
                        addr_d  = target;
                        state_d = FS_BUSY;
                    end else begin
                        // Address must stay stable until the ack; remember to drop it.
                        state_d = FS_DROP;
                    end
                end else if (accept) begin
                    fifo_push = 1'b1;
                    fpc_d     = fpc_q + PC_STEP;
                    if (count_after_push < DEPTH_CNT) begin
                        addr_d  = fpc_q + PC_STEP;
                        state_d = FS_BUSY;
                    end else begin
                        state_d = FS_IDLE;
                    end
                end
            end
            FS_DROP: begin
                if (redirect) fpc_d = target;
                if (accept) begin
                    // Buffer was flushed by the redirect, so there is room.
                    addr_d  = redirect ? target : fpc_q;
                    state_d = FS_BUSY;
                end
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_IDLE;
            fpc_q   <= RESET_PC;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            addr_q  <= addr_d;
        end
    end

    assign fifo_pop = instr_valid && instr_ready;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .flush_i     (redirect),
        .head_data_o (head_entry),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign imem_req  = (state_q != FS_IDLE);
    assign imem_addr = addr_q;

    // Head fields are forced to known values while empty so decode never sees stale data.
    assign instr_valid    = !fifo_empty;
    assign instr          = instr_valid ? head_entry.instr : NOP;
    assign instr_pc       = instr_valid ? head_entry.pc    : 32'h0;
    assign instr_pc_plus4 = instr_pc + PC_STEP;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam int          DEPTH   = 2;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req, imem_ack, redirect, instr_valid, instr_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc, instr_pc_plus4;

    logic        w_req, w_ack, w_valid;
    logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc4;

    instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4)
    );

    instr_fetch_unit #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
        .redirect(1'b0), .redirect_pc(32'h0),
        .instr_valid(w_valid), .instr_ready(1'b1),
        .instr(w_instr), .instr_pc(w_pc), .instr_pc_plus4(w_pc4)
    );

    int          checks = 0;
    int          errors = 0;
    int          age, lat, pops, w_pops;
    bit          rand_lat;
    logic [31:0] exp_pc, w_exp;
    logic [31:0] wrap_tbl [3];

    // Memory image: each word is a fixed scramble of its own address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: memory responders drive at negedge, consumption is scored just
    // before the edge against the program-order model, state checked after it.
    task automatic cycle();
        logic        p_pop, p_accept, p_req, p_redir, p_hold, p_wpop;
        logic [31:0] p_addr, p_pc, p_instr, p_target;
        @(negedge clk);
        if (imem_req) age++;
        imem_ack   = imem_req && (age >= lat);
        imem_rdata = imem_ack ? word_of(imem_addr) : $urandom;
        w_ack      = w_req;
        w_rdata    = word_of(w_addr);
        #1;
        p_pop    = instr_valid && instr_ready && !redirect;
        p_accept = imem_req && imem_ack;
        p_req    = imem_req;
        p_addr   = imem_addr;
        p_redir  = redirect;
        p_target = redirect_pc & ~32'h3;
        p_hold   = instr_valid && !instr_ready && !redirect;
        p_pc     = instr_pc;
        p_instr  = instr;
        p_wpop   = w_valid;
        if (p_pop) begin
            chk("seq_pc", instr_pc, exp_pc);
            chk("seq_instr", instr, word_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (p_wpop) begin
            chk("wrap_pc", w_pc, w_exp);
            chk("wrap_instr", w_instr, word_of(w_exp));
            chk("wrap_pc4", w_pc4, w_exp + 32'd4);
            if (w_pops < 3) chk("wrap_tbl", w_pc, wrap_tbl[w_pops]);
            w_exp = w_exp + 32'd4;
            w_pops++;
        end
        @(posedge clk);
        #1;
        if (p_accept) begin
            age = 0;
            if (rand_lat) lat = $urandom_range(1, 4);
        end
        if (p_redir) exp_pc = p_target;
        if (p_hold) begin
            chk("hold_valid", {31'b0, instr_valid}, 32'd1);
            chk("hold_pc", instr_pc, p_pc);
            chk("hold_instr", instr, p_instr);
        end
        if (p_req && !p_accept) begin
            chk("req_held", {31'b0, imem_req}, 32'd1);
            chk("addr_held", imem_addr, p_addr);
        end
        chk("addr_align", imem_addr & 32'h3, 32'h0);
        chk("pc_plus4", instr_pc_plus4, instr_pc + 32'd4);
    endtask

    task automatic wait_valid(input string tag, input int limit);
        bit found = 1'b0;
        for (int n = 0; n < limit && !found; n++) begin
            cycle();
            if (instr_valid) found = 1'b1;
        end
        chk(tag, {31'b0, found}, 32'd1);
    endtask

    initial begin
        bit          found;
        int          p0;
        logic [31:0] held;

        wrap_tbl[0] = 32'hFFFF_FFF8;
        wrap_tbl[1] = 32'hFFFF_FFFC;
        wrap_tbl[2] = 32'h0000_0000;
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; w_ack = 1'b0; w_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        age = 0; lat = 1; rand_lat = 1'b0; pops = 0; w_pops = 0;
        exp_pc = 32'h0; w_exp = WRAP_PC;

        // Reset values
        #12;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_pc4", instr_pc_plus4, 32'h4);
        chk("rst_wrap_addr", w_addr, WRAP_PC);
        chk("rst_wrap_pc4", w_pc4, 32'h4);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single-cycle memory, decode always ready -> gapless stream
        instr_ready = 1'b1; lat = 1;
        wait_valid("t1_fill", 10);
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("t1_no_gap", {31'b0, instr_valid}, 32'd1);
        end

        // 2: decode stalls -> buffer fills to DEPTH and requests stop
        instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (i >= 5) begin
                chk("t2_req_low", {31'b0, imem_req}, 32'd0);
                chk("t2_valid", {31'b0, instr_valid}, 32'd1);
            end
        end
        lat = 5; instr_ready = 1'b1; p0 = pops;
        for (int i = 0; i < 10 && instr_valid; i++) cycle();
        chk("t2_buffered", 32'(pops - p0), 32'(DEPTH));

        // 3: redirect while a request is in flight -> its word is dropped
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_req && age == 0) found = 1'b1;
            else cycle();
        end
        chk("t3_find_req", {31'b0, found}, 32'd1);
        held = imem_addr;
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        cycle();
        redirect = 1'b0;
        chk("t3_flushed", {31'b0, instr_valid}, 32'd0);
        chk("t3_req_kept", {31'b0, imem_req}, 32'd1);
        chk("t3_addr_kept", imem_addr, held);
        wait_valid("t3_refill", 30);
        chk("t3_target", instr_pc, 32'h0000_0100);

        // 4: redirect coinciding with ack and pop
        lat = 1;
        for (int i = 0; i < 4; i++) cycle();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_req && instr_valid) found = 1'b1;
            else cycle();
        end
        chk("t4_find", {31'b0, found}, 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        cycle();
        redirect = 1'b0;
        chk("t4_empty", {31'b0, instr_valid}, 32'd0);
        chk("t4_req", {31'b0, imem_req}, 32'd1);
        chk("t4_addr", imem_addr, 32'h0000_0100);
        wait_valid("t4_refill", 10);
        chk("t4_target", instr_pc, 32'h0000_0100);

        // 6: asynchronous reset mid-transfer, stale ack right after release
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_req) found = 1'b1;
            else cycle();
        end
        chk("t6_find_req", {31'b0, found}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_req", {31'b0, imem_req}, 32'd0);
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_valid", {31'b0, instr_valid}, 32'd0);
        chk("t6_instr", instr, 32'h0);
        chk("t6_pc4", instr_pc_plus4, 32'h4);
        chk("t6_wrap_addr", w_addr, WRAP_PC);
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; w_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        age = 0; exp_pc = 32'h0; w_exp = WRAP_PC; w_pops = 0;
        @(posedge clk);
        #1;
        chk("t6_first_req", {31'b0, imem_req}, 32'd1);
        chk("t6_first_addr", imem_addr, 32'h0);
        chk("t6_stale_ignored", {31'b0, instr_valid}, 32'd0);
        wait_valid("t6_refill", 20);
        chk("t6_first_pc", instr_pc, 32'h0);

        // Random traffic: stalls, variable latency, redirects to arbitrary targets
        rand_lat = 1'b1;
        for (int i = 0; i < 400; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
            cycle();
            redirect = 1'b0;
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 30; i++) cycle();
        chk("wrap_progress", {31'b0, (w_pops > 3)}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
